// File: rtl/mainfsm_pkg.sv
// mainfsm_pkg: state encoding, Op classes, datapath select constants and the control word shared by mainfsm.
package mainfsm_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMRD    = 4'd3,
        MEMWB    = 4'd4,
        MEMWR    = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        UNKNOWN  = 4'd10
    } state_t;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;
    localparam logic [1:0] OP_ILL = 2'b11;

    localparam logic [1:0] SRCA_REG = 2'b00;
    localparam logic [1:0] SRCA_PC  = 2'b01;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    typedef struct packed {
        logic       irwrite;
        logic       adrsrc;
        logic [1:0] alusrca;
        logic [1:0] alusrcb;
        logic [1:0] resultsrc;
        logic       aluop;
        logic       nextpc;
        logic       regw;
        logic       memw;
        logic       branch;
        logic       instrdone;
    } ctrl_t;

endpackage

// File: rtl/mainfsm_outdec.sv
// mainfsm_outdec: combinational map from FSM state to the packed datapath control word.
module mainfsm_outdec
    import mainfsm_pkg::*;
(
    input  state_t state_i,
    output ctrl_t  ctrl_o
);

    always_comb begin
        ctrl_o           = '0;
        ctrl_o.alusrca   = SRCA_REG;
        ctrl_o.alusrcb   = SRCB_REG;
        ctrl_o.resultsrc = RES_ALUOUT;
        case (state_i)
            FETCH: begin
                ctrl_o.irwrite   = 1'b1;
                ctrl_o.nextpc    = 1'b1;
                ctrl_o.alusrca   = SRCA_PC;
                ctrl_o.alusrcb   = SRCB_FOUR;
                ctrl_o.resultsrc = RES_ALU;
            end
            DECODE: begin
                ctrl_o.alusrca   = SRCA_PC;
                ctrl_o.alusrcb   = SRCB_FOUR;
                ctrl_o.resultsrc = RES_ALU;
            end
            MEMADR: ctrl_o.alusrcb = SRCB_IMM;
            MEMRD:  ctrl_o.adrsrc  = 1'b1;
            MEMWB: begin
                ctrl_o.resultsrc = RES_DATA;
                ctrl_o.regw      = 1'b1;
                ctrl_o.instrdone = 1'b1;
            end
            MEMWR: begin
                ctrl_o.adrsrc    = 1'b1;
                ctrl_o.memw      = 1'b1;
                ctrl_o.instrdone = 1'b1;
            end
            EXECUTER: ctrl_o.aluop = 1'b1;
            EXECUTEI: begin
                ctrl_o.alusrcb = SRCB_IMM;
                ctrl_o.aluop   = 1'b1;
            end
            ALUWB: begin
                ctrl_o.regw      = 1'b1;
                ctrl_o.instrdone = 1'b1;
            end
            BRANCH: begin
                ctrl_o.alusrcb   = SRCB_IMM;
                ctrl_o.resultsrc = RES_ALU;
                ctrl_o.branch    = 1'b1;
                ctrl_o.instrdone = 1'b1;
            end
            // UNKNOWN and every unused encoding: no controls, just finish the instruction
            default: ctrl_o.instrdone = 1'b1;
        endcase
    end

endmodule

// File: rtl/mainfsm.sv
// mainfsm: multi-cycle ARM-subset control FSM; state register, next-state logic and reset gating of controls.
module mainfsm
    import mainfsm_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic       ALUOp,
    output logic       NextPC,
    output logic       RegW,
    output logic       MemW,
    output logic       Branch,
    output logic       InstrDone,
    output logic [3:0] StateOut
);

    state_t state_q, state_d;
    ctrl_t  ctrl, ctrl_g;
    logic   unused_funct;

    assign unused_funct = ^Funct[4:1];

    always_ff @(posedge clk)
        state_q <= !reset ? FETCH : state_d;

    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH: state_d = DECODE;
            DECODE:
                case (Op)
                    OP_DP:   state_d = Funct[5] ? EXECUTEI : EXECUTER;
                    OP_MEM:  state_d = MEMADR;
                    OP_BR:   state_d = BRANCH;
                    OP_ILL:  state_d = UNKNOWN;
                    default: state_d = UNKNOWN;
                endcase
            MEMADR:   state_d = Funct[0] ? MEMRD : MEMWR;
            MEMRD:    state_d = MEMWB;
            EXECUTER: state_d = ALUWB;
            EXECUTEI: state_d = ALUWB;
            default:  state_d = FETCH;
        endcase
    end

    mainfsm_outdec u_outdec (
        .state_i (state_q),
        .ctrl_o  (ctrl)
    );

    // reset gating is combinational so no request escapes while reset is low
    assign ctrl_g    = reset ? ctrl : '0;
    assign StateOut  = reset ? state_q : FETCH;
    assign IRWrite   = ctrl_g.irwrite;
    assign AdrSrc    = ctrl_g.adrsrc;
    assign ALUSrcA   = ctrl_g.alusrca;
    assign ALUSrcB   = ctrl_g.alusrcb;
    assign ResultSrc = ctrl_g.resultsrc;
    assign ALUOp     = ctrl_g.aluop;
    assign NextPC    = ctrl_g.nextpc;
    assign RegW      = ctrl_g.regw;
    assign MemW      = ctrl_g.memw;
    assign Branch    = ctrl_g.branch;
    assign InstrDone = ctrl_g.instrdone;

endmodule

// File: tb/tb_mainfsm.sv
// tb_mainfsm: directed checks of mainfsm state sequences and per-state control words.
module tb_mainfsm;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic       IRWrite, AdrSrc, ALUOp, NextPC, RegW, MemW, Branch, InstrDone;
    logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;
    logic [3:0] StateOut;
    int         checks = 0;
    int         errors = 0;

    // {IRWrite,AdrSrc,ALUSrcA,ALUSrcB,ResultSrc,ALUOp,NextPC,RegW,MemW,Branch,InstrDone}
    localparam logic [14:0] W_FETCH  = {1'b1, 1'b0, 2'b01, 2'b10, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [14:0] W_DECODE = {1'b0, 1'b0, 2'b01, 2'b10, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [14:0] W_MEMADR = {1'b0, 1'b0, 2'b00, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [14:0] W_MEMRD  = {1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [14:0] W_MEMWB  = {1'b0, 1'b0, 2'b00, 2'b00, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    localparam logic [14:0] W_MEMWR  = {1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    localparam logic [14:0] W_EXR    = {1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [14:0] W_EXI    = {1'b0, 1'b0, 2'b00, 2'b01, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [14:0] W_ALUWB  = {1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    localparam logic [14:0] W_BRANCH = {1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    localparam logic [14:0] W_UNK    = 15'b000_0000_0000_0001;
    localparam logic [14:0] W_ZERO   = 15'b0;

    mainfsm dut (
        .clk       (clk),
        .reset     (reset),
        .Op        (Op),
        .Funct     (Funct),
        .IRWrite   (IRWrite),
        .AdrSrc    (AdrSrc),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .ResultSrc (ResultSrc),
        .ALUOp     (ALUOp),
        .NextPC    (NextPC),
        .RegW      (RegW),
        .MemW      (MemW),
        .Branch    (Branch),
        .InstrDone (InstrDone),
        .StateOut  (StateOut)
    );

    always #5 clk = ~clk;

    function automatic logic [14:0] word();
        return {IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp, NextPC, RegW, MemW, Branch, InstrDone};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] st, input logic [14:0] w);
        checks++;
        assert (StateOut === st) else begin
            errors++;
            $error("FAIL %s StateOut observed=%0d expected=%0d", tag, StateOut, st);
        end
        checks++;
        assert (word() === w) else begin
            errors++;
            $error("FAIL %s ctrl observed=%b expected=%b", tag, word(), w);
        end
    endtask

    task automatic cyc(input string tag, input logic [3:0] st, input logic [14:0] w);
        chk(tag, st, w);
        step();
    endtask

    initial begin
        reset = 1'b0;
        Op    = 2'b00;
        Funct = 6'b0;
        step();
        chk("rst1", 4'd0, W_ZERO);
        step();
        chk("rst2", 4'd0, W_ZERO);
        step();
        chk("rst3", 4'd0, W_ZERO);
        reset = 1'b1;
        #1;
        // load
        Op = 2'b01; Funct = 6'b000001;
        cyc("ld_fetch", 4'd0, W_FETCH);
        cyc("ld_decode", 4'd1, W_DECODE);
        cyc("ld_memadr", 4'd2, W_MEMADR);
        Op = 2'b10; Funct = 6'b100000;
        cyc("ld_memrd", 4'd3, W_MEMRD);
        Op = 2'b11; Funct = 6'b111110;
        cyc("ld_memwb", 4'd4, W_MEMWB);
        // store
        Op = 2'b01; Funct = 6'b000000;
        cyc("st_fetch", 4'd0, W_FETCH);
        cyc("st_decode", 4'd1, W_DECODE);
        cyc("st_memadr", 4'd2, W_MEMADR);
        Op = 2'b00; Funct = 6'b111111;
        cyc("st_memwr", 4'd5, W_MEMWR);
        // data-processing register
        Op = 2'b00; Funct = 6'b011110;
        cyc("dpr_fetch", 4'd0, W_FETCH);
        cyc("dpr_decode", 4'd1, W_DECODE);
        Op = 2'b11; Funct = 6'b100000;
        cyc("dpr_exec", 4'd6, W_EXR);
        cyc("dpr_aluwb", 4'd8, W_ALUWB);
        // data-processing immediate
        Op = 2'b00; Funct = 6'b100001;
        cyc("dpi_fetch", 4'd0, W_FETCH);
        cyc("dpi_decode", 4'd1, W_DECODE);
        Op = 2'b01;
        cyc("dpi_exec", 4'd7, W_EXI);
        cyc("dpi_aluwb", 4'd8, W_ALUWB);
        // branch
        Op = 2'b10; Funct = 6'b000000;
        cyc("br_fetch", 4'd0, W_FETCH);
        cyc("br_decode", 4'd1, W_DECODE);
        Op = 2'b01; Funct = 6'b000001;
        cyc("br_branch", 4'd9, W_BRANCH);
        // illegal
        Op = 2'b11; Funct = 6'b000000;
        cyc("ill_fetch", 4'd0, W_FETCH);
        cyc("ill_decode", 4'd1, W_DECODE);
        cyc("ill_unknown", 4'd10, W_UNK);
        // store interrupted by reset in MEMWR
        Op = 2'b01; Funct = 6'b000000;
        cyc("sr_fetch", 4'd0, W_FETCH);
        cyc("sr_decode", 4'd1, W_DECODE);
        cyc("sr_memadr", 4'd2, W_MEMADR);
        chk("sr_memwr", 4'd5, W_MEMWR);
        reset = 1'b0;
        #1;
        chk("sr_gated", 4'd0, W_ZERO);
        step();
        chk("sr_after_edge", 4'd0, W_ZERO);
        reset = 1'b1;
        #1;
        Op = 2'b00; Funct = 6'b000000;
        cyc("sr_release", 4'd0, W_FETCH);
        cyc("sr_decode2", 4'd1, W_DECODE);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
